// File: rtl/text_console_pkg.sv
// Shared constants for the 30x17 text console: geometry, control codes, VRAM address fields
// and controller state encoding.
package text_console_pkg;

  localparam int unsigned TEXT_COLS = 30;
  localparam int unsigned TEXT_ROWS = 17;

  localparam int unsigned ROW_W  = 5;
  localparam int unsigned COL_W  = 5;
  localparam int unsigned ADDR_W = ROW_W + COL_W + 1;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(TEXT_ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(TEXT_COLS - 1);

  localparam logic [7:0] CHR_SPACE = 8'h20;
  localparam logic [7:0] CC_LF     = 8'h0A;
  localparam logic [7:0] CC_CR     = 8'h0D;
  localparam logic [7:0] CC_BS     = 8'h08;
  localparam logic [7:0] CC_FF     = 8'h0C;
  localparam logic [7:0] CC_ESC    = 8'h1B;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_CHR  = 3'd1;
  localparam logic [2:0] ST_WR_ATTR = 3'd2;
  localparam logic [2:0] ST_ESC     = 3'd3;
  localparam logic [2:0] ST_CLR_ROW = 3'd4;
  localparam logic [2:0] ST_CLR_SCR = 3'd5;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

  // Bottom row wraps to the top: port A is write-only, so there is no scroll.
  function automatic logic [ROW_W-1:0] next_row(input logic [ROW_W-1:0] r);
    return (r == LAST_ROW) ? '0 : r + ROW_W'(1);
  endfunction

endpackage

// File: rtl/text_fill.sv
// Address sweep engine for row and screen clears. ada/din present the write to issue on the
// cycle start or step is asserted; done is set once the final write of the sweep has been issued.
module text_fill
  import text_console_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step,
  input  logic              screen,
  input  logic [ROW_W-1:0]  base_row,
  input  logic [7:0]        attr,
  output logic [ADDR_W-1:0] ada,
  output logic [7:0]        din,
  output logic              done
);

  logic [ROW_W-1:0] row_q, row_d, cur_row;
  logic [COL_W-1:0] col_q, col_d, cur_col;
  logic             sel_q, sel_d, cur_sel;
  logic             screen_q, cur_screen;
  logic             done_q, last;

  // A start overrides the counters so the first write of a sweep is available immediately.
  always_comb begin
    cur_row    = start ? (screen ? '0 : base_row) : row_q;
    cur_col    = start ? '0 : col_q;
    cur_sel    = start ? 1'b0 : sel_q;
    cur_screen = start ? screen : screen_q;
    last       = cur_sel && (cur_col == LAST_COL) && (!cur_screen || (cur_row == LAST_ROW));

    row_d = cur_row;
    col_d = cur_col;
    sel_d = ~cur_sel;
    if (cur_sel) begin
      if (cur_col == LAST_COL) begin
        col_d = '0;
        row_d = next_row(cur_row);
      end else begin
        col_d = cur_col + COL_W'(1);
      end
    end
  end

  assign ada  = {cur_row, cur_col, cur_sel};
  assign din  = cur_sel ? attr : CHR_SPACE;
  assign done = done_q;

  // Counters reset to the screen origin so a boot-time screen sweep needs no start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q    <= '0;
      col_q    <= '0;
      sel_q    <= 1'b0;
      screen_q <= 1'b1;
      done_q   <= 1'b0;
    end else if (start || step) begin
      row_q    <= row_d;
      col_q    <= col_d;
      sel_q    <= sel_d;
      screen_q <= cur_screen;
      done_q   <= last;
    end
  end

endmodule

// File: rtl/text_console.sv
// Byte-stream text console driving VRAM port A of the 30x17 text-mode video block.
// Define TEXT_CONSOLE_BOOT_CLEAR_EN to blank the screen with DEFAULT_ATTR out of reset.
module text_console
  import text_console_pkg::*;
#(
  parameter logic [7:0] DEFAULT_ATTR = 8'h07
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic              busy_o,
  output logic              vram_cea_o,
  output logic [ADDR_W-1:0] vram_ada_o,
  output logic [7:0]        vram_din_o,
  output logic [ROW_W-1:0]  cursor_row_o,
  output logic [COL_W-1:0]  cursor_col_o
);

`ifdef TEXT_CONSOLE_BOOT_CLEAR_EN
  localparam logic [2:0] RESET_STATE = ST_CLR_SCR;
`else
  localparam logic [2:0] RESET_STATE = ST_IDLE;
`endif

  logic [2:0]        state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d, row_nl;
  logic [COL_W-1:0]  col_q, col_d;
  logic [7:0]        attr_q, attr_d;
  logic              cea_q, cea_d;
  logic [ADDR_W-1:0] ada_q, ada_d;
  logic [7:0]        din_q, din_d;

  logic              accept;
  logic              fill_start, fill_step, fill_screen, fill_done;
  logic [ADDR_W-1:0] fill_ada;
  logic [7:0]        fill_din;

  assign rx_ready_o = (state_q == ST_IDLE) || (state_q == ST_ESC);
  assign busy_o     = ~rx_ready_o;
  assign accept     = rx_valid_i && rx_ready_o;
  assign row_nl     = next_row(row_q);

  text_fill u_fill (
    .clk      (clk_i),
    .rst_n    (rstn_i),
    .start    (fill_start),
    .step     (fill_step),
    .screen   (fill_screen),
    .base_row (row_nl),
    .attr     (attr_q),
    .ada      (fill_ada),
    .din      (fill_din),
    .done     (fill_done)
  );

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    attr_d      = attr_q;
    cea_d       = 1'b0;
    ada_d       = ada_q;
    din_d       = din_q;
    fill_start  = 1'b0;
    fill_step   = 1'b0;
    fill_screen = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_printable(rx_data_i)) begin
            state_d = ST_WR_CHR;
            cea_d   = 1'b1;
            ada_d   = {row_q, col_q, 1'b0};
            din_d   = rx_data_i;
          end else begin
            case (rx_data_i)
              CC_LF: begin
                col_d      = '0;
                row_d      = row_nl;
                fill_start = 1'b1;
                state_d    = ST_CLR_ROW;
                cea_d      = 1'b1;
                ada_d      = fill_ada;
                din_d      = fill_din;
              end
              CC_CR:  col_d = '0;
              CC_BS:  if (col_q != '0) col_d = col_q - COL_W'(1);
              CC_FF: begin
                fill_start  = 1'b1;
                fill_screen = 1'b1;
                state_d     = ST_CLR_SCR;
                cea_d       = 1'b1;
                ada_d       = fill_ada;
                din_d       = fill_din;
              end
              CC_ESC:  state_d = ST_ESC;
              default: ;
            endcase
          end
        end
      end
      ST_ESC: begin
        if (accept) begin
          attr_d  = rx_data_i;
          state_d = ST_IDLE;
        end
      end
      ST_WR_CHR: begin
        state_d = ST_WR_ATTR;
        cea_d   = 1'b1;
        ada_d   = {row_q, col_q, 1'b1};
        din_d   = attr_q;
      end
      ST_WR_ATTR: begin
        if (col_q != LAST_COL) begin
          col_d   = col_q + COL_W'(1);
          state_d = ST_IDLE;
        end else begin
          col_d      = '0;
          row_d      = row_nl;
          fill_start = 1'b1;
          state_d    = ST_CLR_ROW;
          cea_d      = 1'b1;
          ada_d      = fill_ada;
          din_d      = fill_din;
        end
      end
      ST_CLR_ROW, ST_CLR_SCR: begin
        if (fill_done) begin
          state_d = ST_IDLE;
          if (state_q == ST_CLR_SCR) begin
            row_d = '0;
            col_d = '0;
          end
        end else begin
          fill_step = 1'b1;
          cea_d     = 1'b1;
          ada_d     = fill_ada;
          din_d     = fill_din;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= RESET_STATE;
      row_q   <= '0;
      col_q   <= '0;
      attr_q  <= DEFAULT_ATTR;
      cea_q   <= 1'b0;
      ada_q   <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      attr_q  <= attr_d;
      cea_q   <= cea_d;
      ada_q   <= ada_d;
      din_q   <= din_d;
    end
  end

  assign vram_cea_o   = cea_q;
  assign vram_ada_o   = ada_q;
  assign vram_din_o   = din_q;
  assign cursor_row_o = row_q;
  assign cursor_col_o = col_q;

endmodule

// File: tb/tb_text_console.sv
// Self-checking bench for text_console: directed table, hand sequences for wrap/clear/reset,
// and random bytes against a cell-level reference model.
module tb_text_console;

`ifdef TEXT_CONSOLE_BOOT_CLEAR_EN
  localparam bit BOOT = 1'b1;
`else
  localparam bit BOOT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready, busy, cea;
  logic [10:0] ada;
  logic [7:0]  din;
  logic [4:0]  crow, ccol;

  text_console #(.DEFAULT_ATTR(8'h07)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .rx_data_i    (rx_data),
    .rx_valid_i   (rx_valid),
    .rx_ready_o   (rx_ready),
    .busy_o       (busy),
    .vram_cea_o   (cea),
    .vram_ada_o   (ada),
    .vram_din_o   (din),
    .cursor_row_o (crow),
    .cursor_col_o (ccol)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [18:0] act_w[$];
  logic [18:0] exp_w[$];
  int          exp_busy;
  int          last_busy;
  int          mrow, mcol;
  logic [7:0]  mattr;
  bit          mesc;

  always @(negedge clk) if (cea === 1'b1) act_w.push_back({ada, din});

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void push_cell(input int r, input int c, input logic [7:0] ch,
                                    input logic [7:0] at);
    exp_w.push_back({11'(r * 64 + c * 2), ch});
    exp_w.push_back({11'(r * 64 + c * 2 + 1), at});
  endfunction

  function automatic void model_newline();
    mrow = (mrow + 1) % 17;
    for (int c = 0; c < 30; c++) push_cell(mrow, c, 8'h20, mattr);
    exp_busy += 60;
  endfunction

  function automatic void model_clear_screen();
    for (int r = 0; r < 17; r++)
      for (int c = 0; c < 30; c++) push_cell(r, c, 8'h20, mattr);
  endfunction

  function automatic void model_reset();
    mrow = 0; mcol = 0; mattr = 8'h07; mesc = 1'b0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    exp_w.delete();
    exp_busy = 0;
    if (mesc) begin
      mattr = b;
      mesc  = 1'b0;
    end else if (b >= 8'h20 && b <= 8'h7E) begin
      push_cell(mrow, mcol, b, mattr);
      exp_busy = 2;
      if (mcol == 29) begin
        mcol = 0;
        model_newline();
      end else begin
        mcol++;
      end
    end else begin
      case (b)
        8'h0A: begin mcol = 0; model_newline(); end
        8'h0D: mcol = 0;
        8'h08: if (mcol > 0) mcol--;
        8'h0C: begin model_clear_screen(); exp_busy = 1020; mrow = 0; mcol = 0; end
        8'h1B: mesc = 1'b1;
        default: ;
      endcase
    end
  endfunction

  function automatic void compare_writes(input string name);
    int n;
    int bad;
    checks++;
    n   = (act_w.size() < exp_w.size()) ? act_w.size() : exp_w.size();
    bad = -1;
    for (int i = 0; i < n; i++) if (bad < 0 && act_w[i] !== exp_w[i]) bad = i;
    if (bad >= 0 || act_w.size() != exp_w.size()) begin
      errors++;
      if (bad >= 0)
        $display("FAIL %s: write %0d got ada=%h din=%h expected ada=%h din=%h (n=%0d/%0d)",
                 name, bad, act_w[bad][18:8], act_w[bad][7:0], exp_w[bad][18:8],
                 exp_w[bad][7:0], act_w.size(), exp_w.size());
      else
        $display("FAIL %s: got %0d writes expected %0d", name, act_w.size(), exp_w.size());
    end
  endfunction

  // Called at a negedge; returns at the negedge where rx_ready is seen high again.
  // While busy, valid is toggled with junk data, which must have no effect.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    while (!rx_ready && n < 3000) begin @(negedge clk); n++; end
    check("ready_before_send", rx_ready, 1'b1);
    act_w.delete();
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    model_byte(b);
    last_busy = 0;
    forever begin
      @(negedge clk);
      if (rx_ready) begin
        rx_valid = 1'b0;
        break;
      end
      last_busy++;
      rx_valid = 1'($urandom_range(1));
      rx_data  = 8'($urandom_range(255));
      if (last_busy > 3000) begin
        rx_valid = 1'b0;
        break;
      end
    end
    check("busy_cycles", last_busy, exp_busy);
    compare_writes("writes");
    check("cursor_row", crow, mrow);
    check("cursor_col", ccol, mcol);
  endtask

  task automatic boot_wait();
    int n;
    exp_w.delete();
    model_reset();
    model_clear_screen();
    n = 0;
    while (!rx_ready && n < 3000) begin @(negedge clk); n++; end
    check("boot_ready", rx_ready, 1'b1);
    compare_writes("boot_writes");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cea"}, cea, 1'b0);
    check({tag, "_ada"}, ada, 11'h000);
    check({tag, "_din"}, din, 8'h00);
    check({tag, "_row"}, crow, 5'd0);
    check({tag, "_col"}, ccol, 5'd0);
    check({tag, "_ready"}, rx_ready, !BOOT);
    check({tag, "_busy"}, busy, BOOT);
  endtask

  typedef struct {
    logic [7:0] data;
    int         busy;
    int         row;
    int         col;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int n;
    logic [7:0] b;
    int r;

    vecs[0]  = '{8'h1B, 0, 0, 1};
    vecs[1]  = '{8'h1E, 0, 0, 1};
    vecs[2]  = '{8'h5A, 2, 0, 2};
    vecs[3]  = '{8'h0D, 0, 0, 0};
    vecs[4]  = '{8'h08, 0, 0, 0};
    vecs[5]  = '{8'h85, 0, 0, 0};
    vecs[6]  = '{8'h0A, 60, 1, 0};
    vecs[7]  = '{8'h41, 2, 1, 1};
    vecs[8]  = '{8'h08, 0, 1, 0};
    vecs[9]  = '{8'h0C, 1020, 0, 0};
    vecs[10] = '{8'h08, 0, 0, 0};
    vecs[11] = '{8'h7E, 2, 0, 1};
    vecs[12] = '{8'h20, 2, 0, 2};
    vecs[13] = '{8'h1F, 0, 0, 2};
    vecs[14] = '{8'h7F, 0, 0, 2};

    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rstn = 1'b1;

    if (BOOT) begin
      // Abort the boot clear part-way, then expect a complete restart from address 0.
      n = 0;
      while (act_w.size() < 500 && n < 3000) begin @(negedge clk); n++; end
      check("boot_reach_500", act_w.size(), 500);
      rstn = 1'b0;
      #1;
      check_reset_outputs("boot_abort");
      @(negedge clk);
      act_w.delete();
      rstn = 1'b1;
      boot_wait();
    end
    @(negedge clk);

    // 'A' from (0,0): chr then attr at cell 0.
    send_byte(8'h41);
    check("a_nwr", act_w.size(), 2);
    if (act_w.size() >= 2) begin
      check("a_chr", act_w[0], {11'h000, 8'h41});
      check("a_attr", act_w[1], {11'h001, 8'h07});
    end
    check("a_busy", last_busy, 2);

    foreach (vecs[i]) begin
      send_byte(vecs[i].data);
      check($sformatf("tbl%0d_busy", i), last_busy, vecs[i].busy);
      check($sformatf("tbl%0d_row", i), crow, vecs[i].row);
      check($sformatf("tbl%0d_col", i), ccol, vecs[i].col);
    end

    // Line wrap: 30th byte writes col 29 then clears row 1.
    send_byte(8'h0D);
    for (int i = 0; i < 30; i++) send_byte(8'h78);
    check("wrap_nwr", act_w.size(), 62);
    if (act_w.size() >= 62) begin
      check("wrap_last_chr", act_w[0][18:8], 11'h03A);
      check("wrap_clr_first", act_w[2], {11'h040, 8'h20});
      check("wrap_clr_last", act_w[61], {11'h07B, 8'h1E});
    end
    check("wrap_busy", last_busy, 62);
    check("wrap_row", crow, 5'd1);
    check("wrap_col", ccol, 5'd0);

    // Bottom row LF wraps to row 0 and clears it.
    for (int i = 0; i < 15; i++) send_byte(8'h0A);
    check("row16", crow, 5'd16);
    send_byte(8'h0A);
    check("lfwrap_nwr", act_w.size(), 60);
    if (act_w.size() >= 60) begin
      check("lfwrap_first", act_w[0], {11'h000, 8'h20});
      check("lfwrap_last", act_w[59], {11'h03B, 8'h1E});
    end
    check("lfwrap_row", crow, 5'd0);

    // Reset in the middle of a screen clear aborts at once.
    rx_data  = 8'h0C;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
    act_w.delete();
    n = 0;
    while (act_w.size() < 500 && n < 3000) begin @(negedge clk); n++; end
    check("mid_busy", busy, 1'b1);
    rstn = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    act_w.delete();
    rstn = 1'b1;
    model_reset();
    if (BOOT) boot_wait();
    @(negedge clk);
    send_byte(8'h41);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(99));
      if (r < 58)      b = 8'($urandom_range(8'h7E, 8'h20));
      else if (r < 66) b = 8'h0A;
      else if (r < 71) b = 8'h0D;
      else if (r < 79) b = 8'h08;
      else if (r < 84) b = 8'h1B;
      else if (r < 85) b = 8'h0C;
      else             b = 8'($urandom_range(255));
      send_byte(b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
